// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Holds the FSM encoding and the sequential-PC step.
package fetch_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_INSTR_W = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int PC_INC = 4;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with flush; push lands one cycle later, head is combinational.
// No internal backpressure: push when full or pop when empty is ignored, callers bound occupancy.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != FULL) || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch initiator: issues word-aligned reads, tags and queues in-order responses; cache latency + 1 to output.
// Credit-limited to DEPTH fetches outstanding plus buffered; stall holds the head; branch flushes and drops in-flight.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int                DEPTH    = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [ADDR_W-1:0]  req_addr,
  input  logic               rsp_valid,
  input  logic [INSTR_W-1:0] rsp_instruction,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               stall,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] next_pc;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;
  logic              credit_ok;
  logic              req_fire;
  logic              rsp_taken;
  logic              rsp_drop;
  logic              rsp_push;
  logic              out_pop;
  logic [ADDR_W-1:0] tag_pc;
  entry_t            rsp_entry;
  entry_t            head;

  assign credit_used = {1'b0, inflight} + {1'b0, drop} + {1'b0, fifo_count};
  assign credit_ok   = credit_used < (CW + 1)'(DEPTH);
  assign req_fire    = req_valid && req_ready;
  assign req_addr    = next_pc;

  // A response is owed to a stale fetch first; only with drop at zero is it the oldest live one.
  assign rsp_taken = rsp_valid && ((drop != '0) || (inflight != '0));
  assign rsp_drop  = rsp_valid && (drop != '0);
  assign rsp_push  = rsp_valid && (drop == '0) && (inflight != '0) && !branch_taken;
  assign rsp_entry = '{pc: tag_pc, instr: rsp_instruction};

  assign instr_valid = (fifo_count != '0);
  assign out_pop     = instr_valid && !stall && !branch_taken;
  assign instruction = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:     state_d = FETCH;
      FETCH:    state_d = FETCH;
      REDIRECT: state_d = FETCH;
      default:  state_d = BOOT;
    endcase
    if (branch_taken) state_d = REDIRECT;
  end

  always_comb begin
    req_valid = 1'b0;
    if (state_q == FETCH) req_valid = credit_ok && !branch_taken;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      next_pc <= RESET_PC;
      drop    <= '0;
    end else if (branch_taken) begin
      next_pc <= branch_target & ~ADDR_W'(3);
      drop    <= drop + inflight + CW'(req_fire) - CW'(rsp_taken);
    end else begin
      if (req_fire) next_pc <= next_pc + ADDR_W'(PC_INC);
      if (rsp_drop) drop <= drop - 1'b1;
    end
  end

  // Tag queue occupancy is exactly the number of live in-flight fetches.
  fetch_fifo #(.DEPTH(DEPTH), .W(ADDR_W)) u_tag_q (
    .clock    (clock),
    .reset    (reset),
    .flush    (branch_taken),
    .push     (req_fire),
    .push_dat (next_pc),
    .pop      (rsp_push),
    .head_dat (tag_pc),
    .count    (inflight)
  );

  fetch_fifo #(.DEPTH(DEPTH), .W(ADDR_W + INSTR_W)) u_out_q (
    .clock    (clock),
    .reset    (reset),
    .flush    (branch_taken),
    .push     (rsp_push),
    .push_dat (rsp_entry),
    .pop      (out_pop),
    .head_dat (head),
    .count    (fifo_count)
  );

  a_rsp_expected: assert property (@(posedge clock) disable iff (!reset)
    !(rsp_valid && (inflight == '0) && (drop == '0)));

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Initiator side of the instruction-fetch interface. Generates the PC and issues word-aligned read requests to the instruction cache.
- Collects in-order responses and presents {pc, instruction} to the decode/controller stage through a small skid FIFO.
- Handles branch redirects by flushing queued and in-flight fetches.

Parameters:
- ADDR_W, 32, PC / request address width
- INSTR_W, 32, instruction word width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, max fetches outstanding plus buffered (FIFO entries); power of two, at least 2

Ports:
- clock  input  1  main clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  output  1  fetch request valid
- req_ready  input  1  cache accepts request this cycle
- req_addr  output  ADDR_W  fetch address, bits [1:0] always 0
- rsp_valid  input  1  cache returns a word this cycle (in request order)
- rsp_instruction  input  INSTR_W  returned instruction word
- branch_taken  input  1  redirect pulse from execute
- branch_target  input  ADDR_W  redirect address
- stall  input  1  consumer not accepting this cycle
- instr_valid  output  1  head FIFO entry valid
- instruction  output  INSTR_W  head instruction
- instr_pc  output  ADDR_W  PC of head instruction

Behaviour:
- Reset (async assert, low): next_pc=RESET_PC, req_valid=0, req_addr=RESET_PC, instr_valid=0, instruction=0, instr_pc=0, FIFO empty, inflight=0, drop=0, state=BOOT.
- States:
  - BOOT: one cycle after reset release, then FETCH.
  - FETCH: normal issue.
  - REDIRECT: one-cycle bubble with req_valid=0, then FETCH.
- Issue rule in FETCH: req_valid = (inflight + drop + fifo_count < DEPTH) && !branch_taken. req_addr = next_pc.
- Request handshake: a request is accepted when req_valid && req_ready. On accept: next_pc += 4 (wraps modulo 2^ADDR_W), inflight += 1. req_addr holds stable while req_valid=1 and req_ready=0.
- Response handling:
  - If rsp_valid and drop>0: response discarded, drop -= 1.
  - Otherwise: push {pc tag, rsp_instruction} into the FIFO, inflight -= 1.
  - The pc tag comes from a DEPTH-entry tag queue written at request accept.
  - rsp_valid with inflight=0 and drop=0 is a protocol error: ignored, and flagged by an assertion.
- Output: instr_valid = FIFO non-empty; instruction and instr_pc show the head entry. The head pops when instr_valid && !stall. Push and pop in the same cycle are allowed; count is unchanged.
- Credit rule guarantees the FIFO never overflows. Full means fifo_count == DEPTH.
- Redirect (branch_taken=1, takes priority over everything):
  - next_pc = {branch_target[ADDR_W-1:2], 2'b00}.
  - FIFO flushed, so instr_valid=0 next cycle.
  - drop += inflight, including a request accepted that same cycle and excluding a response arriving that same cycle, which is itself dropped.
  - inflight = 0; state becomes REDIRECT.
  - A pop in the same cycle as a redirect does not occur (the flush wins).
  - Branch while in REDIRECT: retarget, stay in REDIRECT.
- Latency: request-to-output is cache latency + 1 cycle, the FIFO registered push.
- Reset mid-operation: all counters and the FIFO clear immediately. Stale cache responses after reset are not expected; the cache resets on the same signal.

Decomposition:
- Shared package `fetch_pkg`: ADDR_W, INSTR_W, RESET_PC defaults, state encoding (BOOT, FETCH, REDIRECT), PC increment constant 4.
- One sub-module: `fetch_fifo`, a DEPTH x (ADDR_W+INSTR_W) synchronous FIFO with flush, push, pop, count, and async active-low reset. It is reused for the tag queue.

Test Plan:
- Reset release, req_ready=1, 1-cycle cache, stall=0 -> req_addr sequence 0x0, 0x4, 0x8; instr_pc 0x0, 0x4 in order with matching instructions.
- req_ready=0 for 3 cycles at addr 0x8 -> req_addr held at 0x8, req_valid held at 1, next_pc not advanced.
- stall=1 held, responses flowing -> after 2 words, req_valid=0 (credit exhausted); output holds 0x0 until stall drops, then 0x4.
- branch_taken with target 0x103 while 2 fetches in flight -> next req_addr=0x100 after the 1-cycle bubble; the 2 stale responses are dropped; first output instr_pc=0x100.
- Branch coinciding with rsp_valid and a FIFO pop -> that response is dropped, FIFO empty next cycle, no stale instr_pc appears.
- next_pc=0xFFFF_FFFC accepted -> next req_addr=0x0000_0000; reset asserted mid-stream -> all outputs 0 asynchronously, restart at RESET_PC.
